// File: rtl/aes_top.sv
// Iterative AES-128 forward cipher: one round per clock with the round key expanded on the fly.
// A block is captured from idle on AES_en; the ciphertext appears 10 edges later with a valid pulse.
module aes_top (
  input  logic         AES_clk,
  input  logic         AES_rst_n,
  input  logic         AES_en,
  input  logic [127:0] AES_data_in,
  input  logic [127:0] AES_key_in,
  output logic [127:0] AES_data_out,
  output logic         AES_data_out_valid
);

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as a^254 via an addition chain; a=0 maps to 0 naturally.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x15, x240, inv;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    inv  = gf_mul(gf_mul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] cnt);
    case (cnt)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [127:0] state_q, rkey_q, dout_q;
  logic [3:0]   cnt_q;
  logic         busy_q, valid_q;

  logic [127:0] key_nx, sb, sr, mc;
  logic [31:0]  w0n, w1n, w2n, w3n, sub_rot;

  always_comb begin
    sub_rot = {sbox(rkey_q[23:16]), sbox(rkey_q[15:8]), sbox(rkey_q[7:0]), sbox(rkey_q[31:24])};
    w0n     = rkey_q[127:96] ^ sub_rot ^ {rcon(cnt_q), 24'h0};
    w1n     = rkey_q[95:64] ^ w0n;
    w2n     = rkey_q[63:32] ^ w1n;
    w3n     = rkey_q[31:0] ^ w2n;
    key_nx  = {w0n, w1n, w2n, w3n};
  end

  // Byte index 4*c+r sits at bits [127-8*(4c+r) -: 8]; row r rotates left by r columns.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
    end
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= '0;
      rkey_q  <= '0;
      dout_q  <= '0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (!busy_q) begin
        if (AES_en) begin
          state_q <= AES_data_in ^ AES_key_in;
          rkey_q  <= AES_key_in;
          cnt_q   <= 4'd1;
          busy_q  <= 1'b1;
        end
      end else begin
        rkey_q <= key_nx;
        if (cnt_q == 4'd10) begin
          dout_q  <= sr ^ key_nx;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= 4'd0;
        end else begin
          state_q <= mc ^ key_nx;
          cnt_q   <= cnt_q + 4'd1;
        end
      end
    end
  end

  assign AES_data_out       = dout_q;
  assign AES_data_out_valid = valid_q;

endmodule

// File: tb/tb_aes_top.sv
// Bench for aes_top: known-answer vectors, random blocks against a byte-level AES model,
// back-to-back streaming, input isolation and asynchronous reset behaviour.
module tb_aes_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] din, key;
  logic [127:0] dout;
  logic         valid;

  int checks = 0;
  int errors = 0;

  logic [7:0] sbox_tab [256];

  aes_top dut (
    .AES_clk           (clk),
    .AES_rst_n         (rst_n),
    .AES_en            (en),
    .AES_data_in       (din),
    .AES_key_in        (key),
    .AES_data_out      (dout),
    .AES_data_out_valid(valid)
  );

  always #5 clk = ~clk;

  // Carry-less product then polynomial long division by 0x11b.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, s;
    for (int a = 0; a < 256; a++) begin
      inv = 8'h00;
      for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      for (int i = 0; i < 8; i++) begin
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8]
             ^ ((8'h63 >> i) & 8'h01) != 0;
      end
      sbox_tab[a] = s;
    end
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
    logic [31:0]  w [44];
    logic [31:0]  tmp;
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_tab[tmp[23:16]], sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]],
               sbox_tab[tmp[31:24]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sbox_tab[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) begin
          if (rnd < 10)
            s[4*c+r] = gmul(8'h02, t[4*c+r]) ^ gmul(8'h03, t[4*c+(r+1)%4])
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
          else
            s[4*c+r] = t[4*c+r];
        end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd+i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses en for one edge; lat is the edge index (after capture) of the first valid, -1 if none.
  task automatic run_block(input logic [127:0] pt, input logic [127:0] k,
                           output logic [127:0] ct, output int lat);
    din = pt;
    key = k;
    en  = 1'b1;
    step();
    en  = 1'b0;
    lat = -1;
    ct  = 'x;
    for (int e = 1; e <= 20 && lat < 0; e++) begin
      step();
      if (valid === 1'b1) begin
        lat = e;
        ct  = dout;
      end
    end
  endtask

  task automatic check_block(input string name, input logic [127:0] pt, input logic [127:0] k,
                             input logic [127:0] exp);
    logic [127:0] ct;
    int lat;
    run_block(pt, k, ct, lat);
    checks++;
    if (lat !== 10) begin
      errors++;
      $display("FAIL %s latency: got %0d expected 10", name, lat);
    end
    checks++;
    if (ct !== exp) begin
      errors++;
      $display("FAIL %s data: got %h expected %h", name, ct, exp);
    end
    step();
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse width: valid got %b expected 0", name, valid);
    end
  endtask

  task automatic test_reset();
    en = 1'b0;
    din = '0;
    key = '0;
    rst_n = 1'b1;
    #3;
    rst_n = 1'b0;
    #3;
    checks++;
    if (dout !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got out=%h valid=%b expected 0/0", dout, valid);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (dout !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got out=%h valid=%b expected 0/0", dout, valid);
    end
  endtask

  task automatic test_fips();
    check_block("fips_c1", 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    check_block("fips_b", 128'h3243f6a8885a308d313198a2e0370734,
                128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32);
  endtask

  task automatic test_zero_and_isolation();
    int pulses;
    check_block("zero", '0, '0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      din = rand128();
      key = rand128();
      step();
      if (valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL idle_no_valid: got %0d pulses expected 0", pulses);
    end
    checks++;
    if (dout !== 128'h66e94bd4ef8a2c3b884cfa59ca342b2e) begin
      errors++;
      $display("FAIL idle_hold: got %h expected 66e94bd4ef8a2c3b884cfa59ca342b2e", dout);
    end
  endtask

  task automatic test_random();
    logic [127:0] pt, k;
    for (int n = 0; n < 6; n++) begin
      pt = rand128();
      k  = rand128();
      check_block($sformatf("random%0d", n), pt, k, aes_ref(pt, k));
    end
  endtask

  // Edge k captures when k%11==0 and shows valid when k%11==10; other edges see garbage inputs.
  task automatic test_back_to_back();
    logic [127:0] kk, exp;
    int pulses, bad;
    kk  = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;
    exp = aes_ref('0, kk);
    pulses = 0;
    bad = 0;
    for (int k = 0; k < 57; k++) begin
      en  = (k < 51);
      din = (k % 11 == 0) ? '0 : rand128();
      key = (k % 11 == 0) ? kk : rand128();
      step();
      if (valid === 1'b1) pulses++;
      checks++;
      if (valid !== (k % 11 == 10)) begin
        errors++;
        bad++;
        if (bad < 5) $display("FAIL b2b_valid edge %0d: got %b expected %b", k, valid, k % 11 == 10);
      end
      if (k % 11 == 10) begin
        checks++;
        if (dout !== exp) begin
          errors++;
          $display("FAIL b2b_data edge %0d: got %h expected %h", k, dout, exp);
        end
      end
    end
    en = 1'b0;
    checks++;
    if (pulses !== 5) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d expected 5", pulses);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    din = 128'h00112233445566778899aabbccddeeff;
    key = 128'h000102030405060708090a0b0c0d0e0f;
    en  = 1'b1;
    step();
    en  = 1'b0;
    for (int i = 0; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (dout !== '0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got out=%h valid=%b expected 0/0", dout, valid);
    end
    step();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_abort: got %0d pulses expected 0", pulses);
    end
    check_block("post_reset_c1", 128'h00112233445566778899aabbccddeeff,
                128'h000102030405060708090a0b0c0d0e0f, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_zero_and_isolation();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
